// File: rtl/i2c_target.sv
// I2C target (responder) with a fixed 7-bit own address.
// SCL/SDA are oversampled on clk: a 2-flop synchronizer plus one history flop per line.
// START, repeated START and STOP are detected from the synchronized lines.
// Write transfers are ACKed and delivered on rx_data/rx_valid.
// Read transfers shift out bytes fetched from tx_data with a tx_load pulse.
// SDA is open-drain: sda_oe = 1 pulls the line low.
// state_dbg mirrors the FSM state encoding.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] OWN_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rw,
  output logic       busy,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_RX       = 3'd3,
    S_RX_ACK   = 3'd4,
    S_TX       = 3'd5,
    S_TX_ACK   = 3'd6
  } state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       sda_oe_n, tx_load_n, rx_valid_n, rw_n, busy_n;
  logic [7:0] rx_data_n;
  logic [7:0] byte_in;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_h, sda_h;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // Synchronizers and history flops; they reset to the idle-bus level so
  // leaving reset with SCL = SDA = 1 does not look like a START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_h    <= 1'b1;
      sda_h    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_h    <= scl_sync[1];
      sda_h    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda_s;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
  assign byte_in   = {shreg[6:0], sda_s};
  assign state_dbg = state;

  // Next-state and datapath decode; bus conditions override SCL edges.
  // The ACK states use sda_oe itself to tell the first fall (assert) from
  // the second fall (release, end of the 9th clock).
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    sda_oe_n   = sda_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    rw_n       = rw;
    busy_n     = busy;
    if (start_det) begin
      state_n  = S_ADDR;
      cnt_n    = 3'd0;
      sda_oe_n = 1'b0;
    end else if (stop_det) begin
      state_n  = S_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise) begin
            shreg_n = byte_in;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (byte_in[7:1] == OWN_ADDR) begin
                rw_n    = byte_in[0];
                busy_n  = 1'b1;
                state_n = S_ADDR_ACK;
              end else begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
              end
            end
          end
        end
        S_ADDR_ACK, S_TX_ACK: begin
          if (state == S_TX_ACK && scl_rise) begin
            shreg_n = byte_in;
          end else if (scl_fall) begin
            if (state == S_ADDR_ACK && !sda_oe) begin
              sda_oe_n = 1'b1;
            end else if (state == S_ADDR_ACK && !rw) begin
              sda_oe_n = 1'b0;
              state_n  = S_RX;
            end else if (state == S_TX_ACK && shreg[0]) begin
              sda_oe_n = 1'b0;
              state_n  = S_IDLE;
            end else begin
              tx_load_n = 1'b1;
              shreg_n   = tx_data;
              sda_oe_n  = ~tx_data[7];
              cnt_n     = 3'd0;
              state_n   = S_TX;
            end
          end
        end
        S_RX: begin
          if (scl_rise) begin
            shreg_n = byte_in;
            cnt_n   = cnt + 3'd1;
            if (cnt == 3'd7) begin
              rx_data_n  = byte_in;
              rx_valid_n = 1'b1;
              state_n    = S_RX_ACK;
            end
          end
        end
        S_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_n = ~sda_oe;
            if (sda_oe) state_n = S_RX;
          end
        end
        S_TX: begin
          if (scl_fall) begin
            cnt_n = cnt + 3'd1;
            if (cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              state_n  = S_TX_ACK;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              sda_oe_n = ~shreg[6];
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      shreg    <= 8'h00;
      sda_oe   <= 1'b0;
      tx_load  <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      sda_oe   <= sda_oe_n;
      tx_load  <= tx_load_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      rw       <= rw_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master drives SCL/SDA
// over a wired-AND bus, and the target's SDA drive and outputs are compared
// with hand-computed values.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int H = 20;  // clk cycles per SCL half period

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       scl, m_sda;
  logic       sda_line;
  logic       sda_oe, tx_load, rx_valid, rw, busy;
  logic [7:0] tx_data, rx_data;
  logic [2:0] state_dbg;

  assign sda_line = m_sda & ~sda_oe;

  i2c_target #(.OWN_ADDR(7'h42)) dut (
    .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_line),
    .sda_oe(sda_oe), .tx_data(tx_data), .tx_load(tx_load),
    .rx_data(rx_data), .rx_valid(rx_valid), .rw(rw), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [7:0] exp_q[$];
  int rx_cnt = 0;
  int tx_cnt = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      if (exp_q.size() == 0) check("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
      else check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
    end
    if (tx_load) tx_cnt++;
    if (tx_load && rx_valid) overlap++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    wait_clk(H/2); m_sda = 1'b1;
    wait_clk(H/2); scl = 1'b1;
    wait_clk(H/2); m_sda = 1'b0;
    wait_clk(H/2); scl = 1'b0;
  endtask

  task automatic bus_stop();
    wait_clk(H/2); m_sda = 1'b0;
    wait_clk(H/2); scl = 1'b1;
    wait_clk(H/2); m_sda = 1'b1;
    wait_clk(H/2);
  endtask

  task automatic clock_bit(input logic b, output logic oe, output logic ln);
    wait_clk(H/2); m_sda = b;
    wait_clk(H/2); scl = 1'b1;
    wait_clk(H/2); oe = sda_oe; ln = sda_line;
    wait_clk(H/2); scl = 1'b0;
  endtask

  // Nine clocks, MSB first; oe/line collect target drive and bus level mid-high.
  task automatic byte9(input logic [8:0] m, output logic [8:0] oe, output logic [8:0] line);
    logic o, l;
    oe = '0; line = '0;
    for (int i = 8; i >= 0; i--) begin
      clock_bit(m[i], o, l);
      oe   = {oe[7:0], o};
      line = {line[7:0], l};
    end
  endtask

  // ---------------- stimulus ----------------
  logic [8:0] oe, line;
  logic       o, l;

  initial begin
    rst_n = 1'b0; scl = 1'b1; m_sda = 1'b1; tx_data = 8'h00;
    wait_clk(5);
    check("rst_sda_oe",   {31'h0, sda_oe}, 32'h0);
    check("rst_tx_load",  {31'h0, tx_load}, 32'h0);
    check("rst_rx_data",  {24'h0, rx_data}, 32'h0);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_rw",       {31'h0, rw}, 32'h0);
    check("rst_busy",     {31'h0, busy}, 32'h0);
    check("rst_state",    {29'h0, state_dbg}, 32'h0);
    rst_n = 1'b1;
    wait_clk(10);
    check("idle_after_rst", {29'h0, state_dbg}, 32'h0);

    // Write transfer: 0x84, 0xA5.
    bus_start();
    byte9({8'h84, 1'b1}, oe, line);
    check("wr_addr_oe", {23'h0, oe}, 32'h001);
    check("wr_busy", {31'h0, busy}, 32'h1);
    check("wr_rw", {31'h0, rw}, 32'h0);
    exp_q.push_back(8'hA5);
    byte9({8'hA5, 1'b1}, oe, line);
    check("wr_data_oe", {23'h0, oe}, 32'h001);
    bus_stop();
    wait_clk(5);
    check("wr_busy_stop", {31'h0, busy}, 32'h0);
    check("wr_state_stop", {29'h0, state_dbg}, 32'h0);
    check("wr_rx_cnt", rx_cnt, 1);

    // Address mismatch: 0x86, 0x11.
    bus_start();
    byte9({8'h86, 1'b1}, oe, line);
    check("mm_addr_oe", {23'h0, oe}, 32'h000);
    byte9({8'h11, 1'b1}, oe, line);
    check("mm_data_oe", {23'h0, oe}, 32'h000);
    check("mm_busy", {31'h0, busy}, 32'h0);
    check("mm_rx_cnt", rx_cnt, 1);
    check("mm_rx_data", {24'h0, rx_data}, 32'hA5);
    bus_stop();

    // Read transfer: 0x85, byte 0x3C with ACK, byte 0xFF with NACK.
    tx_data = 8'h3C;
    bus_start();
    byte9({8'h85, 1'b1}, oe, line);
    check("rd_addr_oe", {23'h0, oe}, 32'h001);
    wait_clk(6);
    check("rd_rw", {31'h0, rw}, 32'h1);
    check("rd_load1", tx_cnt, 1);
    tx_data = 8'hFF;
    byte9(9'h1FE, oe, line);
    check("rd_b1_oe", {23'h0, oe}, 32'h186);
    check("rd_b1_line", {23'h0, line}, 32'h078);
    byte9(9'h1FF, oe, line);
    check("rd_b2_oe", {23'h0, oe}, 32'h000);
    check("rd_b2_line", {23'h0, line}, 32'h1FF);
    wait_clk(6);
    check("rd_nack_state", {29'h0, state_dbg}, 32'h0);
    check("rd_nack_oe", {31'h0, sda_oe}, 32'h0);
    check("rd_nack_busy", {31'h0, busy}, 32'h1);
    check("rd_load_cnt", tx_cnt, 2);
    bus_stop();
    wait_clk(5);
    check("rd_busy_stop", {31'h0, busy}, 32'h0);

    // Repeated START: write 0x5A, Sr, read one byte 0x77 with NACK.
    bus_start();
    byte9({8'h84, 1'b1}, oe, line);
    exp_q.push_back(8'h5A);
    byte9({8'h5A, 1'b1}, oe, line);
    check("sr_data_oe", {23'h0, oe}, 32'h001);
    check("sr_rw0", {31'h0, rw}, 32'h0);
    tx_data = 8'h77;
    bus_start();
    byte9({8'h85, 1'b1}, oe, line);
    check("sr_addr_oe", {23'h0, oe}, 32'h001);
    wait_clk(6);
    check("sr_rw1", {31'h0, rw}, 32'h1);
    check("sr_load", tx_cnt, 3);
    check("sr_rx_data", {24'h0, rx_data}, 32'h5A);
    byte9(9'h1FF, oe, line);
    check("sr_rd_oe", {23'h0, oe}, 32'h110);
    check("sr_rd_line", {23'h0, line}, 32'h0EF);
    bus_stop();

    // Interrupted byte: STOP after 4 data bits.
    bus_start();
    byte9({8'h84, 1'b1}, oe, line);
    for (int i = 0; i < 4; i++) clock_bit(i[0], o, l);
    bus_stop();
    wait_clk(5);
    check("int_state", {29'h0, state_dbg}, 32'h0);
    check("int_rx_cnt", rx_cnt, 2);
    check("int_rx_data", {24'h0, rx_data}, 32'h5A);
    check("int_busy", {31'h0, busy}, 32'h0);

    // Reset while the target drives SDA during a read.
    tx_data = 8'h00;
    bus_start();
    byte9({8'h85, 1'b1}, oe, line);
    wait_clk(6);
    check("rr_oe_before", {31'h0, sda_oe}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rr_oe_async", {31'h0, sda_oe}, 32'h0);
    scl = 1'b1; m_sda = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    check("rr_state", {29'h0, state_dbg}, 32'h0);
    check("rr_busy", {31'h0, busy}, 32'h0);
    bus_start();
    byte9({8'h84, 1'b1}, oe, line);
    check("rr_addr_oe", {23'h0, oe}, 32'h001);
    exp_q.push_back(8'h3C);
    byte9({8'h3C, 1'b1}, oe, line);
    check("rr_data_oe", {23'h0, oe}, 32'h001);
    bus_stop();
    wait_clk(5);
    check("rr_rx_cnt", rx_cnt, 3);
    check("rr_tx_cnt", tx_cnt, 4);

    check("exp_q_empty", exp_q.size(), 0);
    check("no_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Bus-side I2C target (responder). It is the other end of the start/address/data initiator path on the I2C master.
- Oversamples SCL/SDA on the system clock, detects START, repeated START and STOP, and matches a 7-bit own address.
- Write transfers: ACKs and delivers received bytes. Read transfers: shifts out bytes supplied by local logic.
- Sits between the chip pads (open-drain SDA) and a register bank.

Parameters:
- OWN_ADDR, 7'h42, 7-bit target address compared against the first byte after START.

Ports:
- clk  input  1  system clock; period <= 1/10 of minimum SCL high or low time
- rst_n  input  1  reset; asynchronous, active-low
- scl  input  1  bus SCL, asynchronous to clk
- sda_in  input  1  bus SDA pad input, asynchronous to clk
- sda_oe  output  1  1 = pull SDA low; 0 = release (open-drain)
- tx_data  input  8  byte to return on read; sampled when tx_load pulses
- tx_load  output  1  one-clk pulse; tx_data captured this cycle
- rx_data  output  8  last byte received in a write transfer
- rx_valid  output  1  one-clk pulse; rx_data updated this cycle
- rw  output  1  R/W bit of the last matched address byte (1 = read)
- busy  output  1  high from address match until STOP or mismatch

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: sda_oe 0, tx_load 0, rx_data 8'h00, rx_valid 0, rw 0, busy 0, state IDLE, bit counter 0.
- SCL/SDA synchronizer and history flops reset to 1 (idle bus), so releasing reset with the bus high produces no START.
- Input path: 2-flop synchronizer per line, then one history flop. Edges and conditions are seen 3 clk after the pin change.
- START: sda falls while scl high. STOP: sda rises while scl high.
- START and STOP take priority over SCL-edge processing in the same cycle.
- START in any state: go to ADDR, clear bit counter, sda_oe 0. This covers repeated START.
- STOP in any state: go to IDLE, sda_oe 0, busy 0.
- All bytes are MSB first.
- Bit counter is 3 bits. The 8th edge is detected at count 7; the counter wraps to 0.
- IDLE: ignore SCL; wait for START.
- ADDR:
  - Shift sda on each SCL rise.
  - After the 8th rise, if byte[7:1] == OWN_ADDR: set rw = byte[0], busy 1, go ADDR_ACK.
  - Otherwise go IDLE with sda_oe held 0; no outputs change.
- ADDR_ACK:
  - On the next SCL fall, sda_oe 1.
  - On the following fall (end of the 9th clock), sda_oe 0 and go RX if rw = 0.
  - If rw = 1, go TX with the load step below in that same cycle.
- RX:
  - Shift on SCL rises.
  - After the 8th rise: rx_data <= byte, rx_valid pulses 1 clk, go RX_ACK.
- RX_ACK: assert sda_oe on the next SCL fall, release on the following fall, return to RX.
- TX load step:
  - tx_load pulses; shift register <= tx_data.
  - sda_oe <= ~tx_data[7], same clk as the SCL fall.
- TX:
  - On each following SCL fall, shift left and drive sda_oe <= ~next bit.
  - On the 8th fall, sda_oe 0 and go TX_ACK.
- TX_ACK: sample sda on the 9th SCL rise.
  - 0 (master ACK): on the 9th fall, perform the load step and continue in TX.
  - 1 (NACK): go IDLE and stay released until START or STOP; busy stays 1 until STOP.
- While sda_oe = 1, START/STOP detection on SDA is still active and overrides.
- rx_valid and tx_load never assert in the same cycle.
- Neither rx_valid nor tx_load asserts outside a matched transfer.

Test Plan:
- Write transfer:
  - Stimulus: START, 0x84, 0xA5, STOP.
  - Response: sda_oe = 1 across both 9th clocks; rx_data = 0xA5 with one rx_valid pulse; rw = 0; busy 0 after STOP.
- Address mismatch:
  - Stimulus: START, 0x86, 0x11.
  - Response: sda_oe stays 0 throughout; no rx_valid; busy 0.
- Read transfer:
  - Stimulus: START, 0x85; tx_data = 0x3C; master ACK; tx_data = 0xFF; master NACK; STOP.
  - Response: tx_load pulses twice; sda_oe sequence over the first byte is 1,1,0,0,0,0,1,1; sda_oe = 0 after the NACK until STOP.
- Repeated START:
  - Stimulus: START, 0x84, 0x5A, Sr, 0x85.
  - Response: rx_data = 0x5A; rw switches to 1; tx_load pulses after the address ACK.
- Interrupted byte:
  - Stimulus: STOP after 4 bits of a write data byte.
  - Response: return to IDLE; no rx_valid; rx_data unchanged.
- Reset mid-read:
  - Stimulus: rst_n low while sda_oe = 1; release rst_n with SCL = SDA = 1.
  - Response: sda_oe drops to 0 asynchronously; no START detected; the next valid START is accepted normally.
